eth_pkt_sf_fifo: RTL and testbench

Single-clock, packet-mode store-and-forward FIFO in the clk_125 domain. It sits between the TX CDC FIFO output and the MAC TX AXI-Stream input. The MAC only ever sees complete, error-free packets, so it never underruns mid-frame. This generalises the packet-counter gating in the top level:
- parametrised width, depth and packet count;
- bad-frame drop (tuser);
- oversize/overflow drop with pointer rollback;
- occupancy status.

---
 rtl/eth_pkt_sf_fifo.sv | 191 +++++++++++++++++++
 tb/tb_eth_pkt_sf_fifo.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_pkt_sf_fifo.sv
// Packet-mode store-and-forward FIFO for the clk_125 MAC TX path.
// The MAC sees only complete, good frames. Bad frames (tuser) and overflowing frames are rolled back.
module eth_pkt_sf_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4096,
   parameter int MAX_PKTS   = 64,
   parameter int CNT_W      = $clog2(MAX_PKTS + 1)
) (
   input  logic                    clk_125,
   input  logic                    i_reset_n,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic                    s_axis_tvalid,
   input  logic                    s_axis_tlast,
   input  logic                    s_axis_tuser,
   output logic                    s_axis_trdy,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic                    m_axis_tvalid,
   output logic                    m_axis_tlast,
   input  logic                    m_axis_trdy,
   output logic [CNT_W-1:0]        o_pkt_count,
   output logic [$clog2(DEPTH):0]  o_level,
   output logic                    o_drop_pulse,
   output logic                    o_overflow_pulse
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic [1:0] {
      W_IDLE,
      W_PKT,
      W_DROP
   } wr_state_t;

   wr_state_t              r_wr_state;
   wr_state_t              w_wr_state_nxt;

   logic [PW-1:0]          r_wr_cur;
   logic [PW-1:0]          r_wr_commit;
   logic [PW-1:0]          r_rd;
   logic [PW-1:0]          w_wr_cur_nxt;
   logic [PW-1:0]          w_wr_commit_nxt;
   logic [PW-1:0]          w_level;

   logic [CNT_W-1:0]       r_pkt_count;
   logic                   r_drop_pulse;
   logic                   r_overflow_pulse;

   logic [DATA_WIDTH:0]    r_mem [DEPTH];
   logic [DATA_WIDTH:0]    r_ram_q;
   logic                   r_s1_valid;
   logic [DATA_WIDTH-1:0]  r_out_data;
   logic                   r_out_last;
   logic                   r_out_valid;

   logic                   w_full;
   logic                   w_wr_acc;
   logic                   w_mem_we;
   logic                   w_commit;
   logic                   w_drop;
   logic                   w_overflow;
   logic                   w_out_ready;
   logic                   w_rd_en;
   logic                   w_pop_last;

   // Occupancy counts uncommitted words too, so a frame being written cannot be overrun.
   assign w_level     = r_wr_cur - r_rd;
   assign w_full      = (w_level == PW'(DEPTH));
   assign s_axis_trdy = i_reset_n && (r_pkt_count != CNT_W'(MAX_PKTS));
   assign w_wr_acc    = s_axis_tvalid && s_axis_trdy;

   // NOTE: every signal gets a default before the case, so no path can infer a latch.
   always_comb begin
      w_wr_state_nxt  = r_wr_state;
      w_wr_cur_nxt    = r_wr_cur;
      w_wr_commit_nxt = r_wr_commit;
      w_mem_we        = 1'b0;
      w_commit        = 1'b0;
      w_drop          = 1'b0;
      w_overflow      = 1'b0;
      if (w_wr_acc) begin
         case (r_wr_state)
            W_IDLE, W_PKT: begin
               if (!w_full) begin
                  w_mem_we = 1'b1;
                  if (!s_axis_tlast) begin
                     w_wr_cur_nxt   = r_wr_cur + 1'b1;
                     w_wr_state_nxt = W_PKT;
                  end else if (!s_axis_tuser) begin
                     w_wr_cur_nxt    = r_wr_cur + 1'b1;
                     w_wr_commit_nxt = r_wr_cur + 1'b1;
                     w_commit        = 1'b1;
                     w_wr_state_nxt  = W_IDLE;
                  end else begin
                     w_wr_cur_nxt   = r_wr_commit;
                     w_drop         = 1'b1;
                     w_wr_state_nxt = W_IDLE;
                  end
               end else begin
                  // No room for this beat: give back the partial frame and swallow the rest.
                  w_wr_cur_nxt = r_wr_commit;
                  if (s_axis_tlast) begin
                     w_overflow     = 1'b1;
                     w_wr_state_nxt = W_IDLE;
                  end else begin
                     w_wr_state_nxt = W_DROP;
                  end
               end
            end
            W_DROP: begin
               if (s_axis_tlast) begin
                  w_overflow     = 1'b1;
                  w_wr_state_nxt = W_IDLE;
               end
            end
            default: w_wr_state_nxt = W_IDLE;
         endcase
      end
   end

   // The read path is a RAM stage (r_s1_valid) followed by an output register.
   // A word is fetched whenever committed data exists and stage 1 is free or draining.
   assign w_out_ready = !r_out_valid || m_axis_trdy;
   assign w_rd_en     = (r_rd != r_wr_commit) && (!r_s1_valid || w_out_ready);
   assign w_pop_last  = r_out_valid && m_axis_trdy && r_out_last;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_125) begin
      if (!i_reset_n) begin
         r_wr_state       <= W_IDLE;
         r_wr_cur         <= '0;
         r_wr_commit      <= '0;
         r_rd             <= '0;
         r_pkt_count      <= '0;
         r_drop_pulse     <= 1'b0;
         r_overflow_pulse <= 1'b0;
         r_s1_valid       <= 1'b0;
         r_out_valid      <= 1'b0;
      end else begin
         r_wr_state       <= w_wr_state_nxt;
         r_wr_cur         <= w_wr_cur_nxt;
         r_wr_commit      <= w_wr_commit_nxt;
         r_drop_pulse     <= w_drop;
         r_overflow_pulse <= w_overflow;

         if (w_rd_en) begin
            r_rd       <= r_rd + 1'b1;
            r_s1_valid <= 1'b1;
         end else if (w_out_ready) begin
            r_s1_valid <= 1'b0;
         end

         if (w_out_ready) begin
            r_out_valid <= r_s1_valid;
         end

         case ({w_commit, w_pop_last})
            2'b10:   r_pkt_count <= r_pkt_count + 1'b1;
            2'b01:   r_pkt_count <= r_pkt_count - 1'b1;
            default: r_pkt_count <= r_pkt_count;
         endcase
      end
   end

   // NOTE: storage and data registers have no reset so they map onto block RAM.
   // Whether a word is valid is tracked only by the pointers and valid flags.
   always_ff @(posedge clk_125) begin
      if (w_mem_we) begin
         r_mem[r_wr_cur[AW-1:0]] <= {s_axis_tdata, s_axis_tlast};
      end
      if (w_rd_en) begin
         r_ram_q <= r_mem[r_rd[AW-1:0]];
      end
   end

   always_ff @(posedge clk_125) begin
      if (w_out_ready && r_s1_valid) begin
         r_out_data <= r_ram_q[DATA_WIDTH:1];
         r_out_last <= r_ram_q[0];
      end
   end

   assign m_axis_tdata     = r_out_data;
   assign m_axis_tlast     = r_out_last;
   assign m_axis_tvalid    = r_out_valid;
   assign o_pkt_count      = r_pkt_count;
   assign o_level          = w_level;
   assign o_drop_pulse     = r_drop_pulse;
   assign o_overflow_pulse = r_overflow_pulse;

endmodule

// File: tb/tb_eth_pkt_sf_fifo.sv
// Directed bench for eth_pkt_sf_fifo with DEPTH=16 and MAX_PKTS=2.
// Inputs change and outputs are sampled on the falling edge of clk_125.
module tb_eth_pkt_sf_fifo;

   logic        clk_125 = 1'b0;
   logic        i_reset_n;
   logic [7:0]  s_tdata;
   logic        s_tvalid;
   logic        s_tlast;
   logic        s_tuser;
   logic        s_trdy;
   logic [7:0]  m_tdata;
   logic        m_tvalid;
   logic        m_tlast;
   logic        m_trdy;
   logic [1:0]  pkt_count;
   logic [4:0]  level;
   logic        drop_pulse;
   logic        overflow_pulse;

   int checks = 0;
   int errors = 0;

   eth_pkt_sf_fifo #(
      .DATA_WIDTH (8),
      .DEPTH      (16),
      .MAX_PKTS   (2)
   ) dut (
      .clk_125          (clk_125),
      .i_reset_n        (i_reset_n),
      .s_axis_tdata     (s_tdata),
      .s_axis_tvalid    (s_tvalid),
      .s_axis_tlast     (s_tlast),
      .s_axis_tuser     (s_tuser),
      .s_axis_trdy      (s_trdy),
      .m_axis_tdata     (m_tdata),
      .m_axis_tvalid    (m_tvalid),
      .m_axis_tlast     (m_tlast),
      .m_axis_trdy      (m_trdy),
      .o_pkt_count      (pkt_count),
      .o_level          (level),
      .o_drop_pulse     (drop_pulse),
      .o_overflow_pulse (overflow_pulse)
   );

   always #4 clk_125 = ~clk_125;

   task automatic tick();
      @(negedge clk_125);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tuser  = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic last, input logic user);
      check("s_trdy_before_beat", 32'(s_trdy), 32'd1);
      s_tdata  = d;
      s_tvalid = 1'b1;
      s_tlast  = last;
      s_tuser  = user;
      tick();
   endtask

   // Waits (bounded) for tvalid, then expects n consecutive values starting at 'first'.
   task automatic read_expect(input logic [7:0] first, input int n);
      int t = 0;
      while (!m_tvalid && t < 20) begin
         tick();
         t++;
      end
      check("rd_valid_wait", 32'(m_tvalid), 32'd1);
      for (int i = 0; i < n; i++) begin
         check("rd_tvalid", 32'(m_tvalid), 32'd1);
         check("rd_tdata", 32'(m_tdata), 32'(first + 8'(i)));
         check("rd_tlast", 32'(m_tlast), 32'(i == n - 1));
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      i_reset_n = 1'b0;
      m_trdy    = 1'b0;
      s_tdata   = '0;
      idle();
      repeat (3) tick();
      check("rst_tvalid", 32'(m_tvalid), 32'd0);
      check("rst_count", 32'(pkt_count), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_trdy", 32'(s_trdy), 32'd0);
      check("rst_drop", 32'(drop_pulse), 32'd0);
      check("rst_ovf", 32'(overflow_pulse), 32'd0);
      i_reset_n = 1'b1;
      tick();
      check("post_rst_trdy", 32'(s_trdy), 32'd1);

      // 5-beat packet, 2-cycle latency, back-to-back readout.
      m_trdy = 1'b1;
      for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), i == 4, 1'b0);
      idle();
      check("t1_count_commit", 32'(pkt_count), 32'd1);
      check("t1_level", 32'(level), 32'd5);
      check("t1_tvalid_e0", 32'(m_tvalid), 32'd0);
      tick();
      check("t1_tvalid_e1", 32'(m_tvalid), 32'd0);
      tick();
      check("t1_tvalid_e2", 32'(m_tvalid), 32'd1);
      read_expect(8'h10, 5);
      check("t1_count_end", 32'(pkt_count), 32'd0);
      check("t1_tvalid_end", 32'(m_tvalid), 32'd0);
      check("t1_level_end", 32'(level), 32'd0);

      // Stalled partial packet stays invisible.
      for (int i = 0; i < 4; i++) send(8'h20 + 8'(i), 1'b0, 1'b0);
      idle();
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t2_no_tvalid", 32'(m_tvalid), 32'd0);
      end
      check("t2_level", 32'(level), 32'd4);
      check("t2_count", 32'(pkt_count), 32'd0);
      send(8'h24, 1'b1, 1'b0);
      idle();
      read_expect(8'h20, 5);

      // Bad frame dropped, following good frame delivered.
      send(8'h30, 1'b0, 1'b0);
      send(8'h31, 1'b0, 1'b0);
      send(8'h32, 1'b1, 1'b1);
      idle();
      check("t3_drop_pulse", 32'(drop_pulse), 32'd1);
      check("t3_no_ovf", 32'(overflow_pulse), 32'd0);
      check("t3_level_rb", 32'(level), 32'd0);
      check("t3_count", 32'(pkt_count), 32'd0);
      tick();
      check("t3_drop_once", 32'(drop_pulse), 32'd0);
      check("t3_no_tvalid", 32'(m_tvalid), 32'd0);
      send(8'hA0, 1'b0, 1'b0);
      send(8'hA1, 1'b1, 1'b0);
      idle();
      read_expect(8'hA0, 2);
      check("t3_tvalid_end", 32'(m_tvalid), 32'd0);
      check("t3_level_end", 32'(level), 32'd0);

      // Oversize frame: beats 17..20 discarded, then a DEPTH-beat frame fits.
      m_trdy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         send(8'h40 + 8'(i), i == 19, 1'b0);
         if (i == 15) check("t4_level_full", 32'(level), 32'd16);
         if (i == 16) check("t4_level_rb", 32'(level), 32'd0);
         if (i == 18) check("t4_no_early_ovf", 32'(overflow_pulse), 32'd0);
      end
      idle();
      check("t4_ovf_pulse", 32'(overflow_pulse), 32'd1);
      check("t4_level", 32'(level), 32'd0);
      check("t4_count", 32'(pkt_count), 32'd0);
      check("t4_no_tvalid", 32'(m_tvalid), 32'd0);
      tick();
      check("t4_ovf_once", 32'(overflow_pulse), 32'd0);
      for (int i = 0; i < 16; i++) send(8'h60 + 8'(i), i == 15, 1'b0);
      idle();
      check("t4_full_level", 32'(level), 32'd16);
      check("t4_full_count", 32'(pkt_count), 32'd1);
      check("t4_full_no_ovf", 32'(overflow_pulse), 32'd0);
      repeat (4) tick();
      check("t4_hold_valid", 32'(m_tvalid), 32'd1);
      check("t4_hold_data", 32'(m_tdata), 32'h60);
      tick();
      check("t4_hold_data2", 32'(m_tdata), 32'h60);
      check("t4_level_pipe", 32'(level), 32'd14);
      m_trdy = 1'b1;
      read_expect(8'h60, 16);
      check("t4_count_end", 32'(pkt_count), 32'd0);
      check("t4_level_end", 32'(level), 32'd0);

      // Packet-count limit backpressures the writer.
      m_trdy = 1'b0;
      send(8'h71, 1'b1, 1'b0);
      check("t5_count1", 32'(pkt_count), 32'd1);
      send(8'h72, 1'b1, 1'b0);
      check("t5_count2", 32'(pkt_count), 32'd2);
      check("t5_trdy_low", 32'(s_trdy), 32'd0);
      s_tdata  = 8'h73;
      s_tvalid = 1'b1;
      s_tlast  = 1'b1;
      s_tuser  = 1'b0;
      repeat (3) tick();
      check("t5_trdy_still_low", 32'(s_trdy), 32'd0);
      check("t5_count_hold", 32'(pkt_count), 32'd2);
      check("t5_head_valid", 32'(m_tvalid), 32'd1);
      check("t5_head_data", 32'(m_tdata), 32'h71);
      m_trdy = 1'b1;
      tick();
      check("t5_trdy_back", 32'(s_trdy), 32'd1);
      check("t5_count_dec", 32'(pkt_count), 32'd1);
      check("t5_next_data", 32'(m_tdata), 32'h72);
      tick();
      check("t5_count_simul", 32'(pkt_count), 32'd1);
      idle();
      read_expect(8'h73, 1);
      check("t5_count_end", 32'(pkt_count), 32'd0);

      // Reset in the middle of a readout.
      for (int i = 0; i < 6; i++) send(8'h80 + 8'(i), i == 5, 1'b0);
      idle();
      tick();
      tick();
      check("t6_first_valid", 32'(m_tvalid), 32'd1);
      check("t6_first_data", 32'(m_tdata), 32'h80);
      tick();
      check("t6_second_data", 32'(m_tdata), 32'h81);
      i_reset_n = 1'b0;
      tick();
      check("t6_rst_tvalid", 32'(m_tvalid), 32'd0);
      check("t6_rst_count", 32'(pkt_count), 32'd0);
      check("t6_rst_level", 32'(level), 32'd0);
      check("t6_rst_trdy", 32'(s_trdy), 32'd0);
      i_reset_n = 1'b1;
      tick();
      check("t6_rel_trdy", 32'(s_trdy), 32'd1);
      repeat (3) tick();
      check("t6_no_stale", 32'(m_tvalid), 32'd0);
      check("t6_rel_level", 32'(level), 32'd0);
      send(8'h90, 1'b0, 1'b0);
      send(8'h91, 1'b1, 1'b0);
      idle();
      read_expect(8'h90, 2);
      repeat (4) tick();
      check("t6_no_old_beats", 32'(m_tvalid), 32'd0);
      check("t6_final_count", 32'(pkt_count), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
